// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared RAM constants and dump reader state encoding
package ram_pkg;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 8;
    localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } reader_state_t;

endpackage

// File: rtl/ram_dump_reader.sv
// rtl/ram_dump_reader.sv - streams length consecutive RAM bytes from base_addr over valid/ready
module ram_dump_reader
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rw,
    output logic              ram_mv,
    output logic              ram_enable_n,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(1) << ADDR_W;
    localparam logic [1:0]       LAT_LAST = 2'(RD_LAT - 1);

    reader_state_t     state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic [1:0]        lat_cnt;
    logic [LEN_W-1:0]  len_clamped;

    assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;

    // Strobes decode straight from state so an async reset drops them at once.
    assign busy         = (state == REQ) || (state == WAIT) || (state == HOLD);
    assign done         = (state == DONE);
    assign ram_mv       = (state == REQ);
    assign out_valid    = (state == HOLD);
    assign ram_enable_n = ~busy;
    assign ram_rw       = READ;
    assign ram_addr     = addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            lat_cnt   <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= len_clamped;
                        state     <= (len_clamped == '0) ? DONE : REQ;
                    end
                end
                REQ: begin
                    lat_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        out_data <= ram_dout;
                        state    <= HOLD;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                HOLD: begin
                    // Address wraps modulo 2^ADDR_W so a full dump covers every location once.
                    if (out_ready) begin
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        state     <= (remaining == LEN_W'(1)) ? DONE : REQ;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
